// File: rtl/axis_udp_pkt_generator_if.sv
// AXI-Stream bundle for the UDP/CMAC TX packet generator.
// The master drives the payload and the slave drives tready.
interface axis_udp_pkt_generator_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/axis_udp_pkt_generator.sv
// Synthetic AXI-Stream packet source with a self-describing payload and
// TX packet, beat and cycle counters for throughput measurement.
module axis_udp_pkt_generator #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [15:0]                     pkt_size,
  input  logic [31:0]                     pkt_interval,
  input  logic [31:0]                     pkt_num,
  axis_udp_pkt_generator_if.master        m_axis,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     sent_pkt_count,
  output logic [31:0]                     total_beat_count,
  output logic [31:0]                     run_cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [9:0]            beat_q, beat_d;
  logic [9:0]            last_beat_q, last_beat_d;
  logic [6:0]            rem_q, rem_d;
  logic [15:0]           seq_q, seq_d;
  logic [31:0]           interval_q, interval_d;
  logic [31:0]           gap_q, gap_d;
  logic [31:0]           num_q, num_d;
  logic [31:0]           sent_q, sent_d;
  logic [31:0]           beats_q, beats_d;
  logic [31:0]           cycles_q, cycles_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  hs;
  logic                  start_pkt;
  logic                  load;
  logic [15:0]           size_m1;
  logic [9:0]            new_last_beat;
  logic [6:0]            new_rem;

  // Size 0 behaves as 1 byte; size-1 splits into last-beat index and residue.
  assign size_m1       = (pkt_size == 16'd0) ? 16'd0 : pkt_size - 16'd1;
  assign new_last_beat = size_m1[15:6];
  assign new_rem       = {1'b0, size_m1[5:0]} + 7'd1;
  assign hs            = tvalid_q & m_axis.tready;

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [15:0] seq,
                                                      input logic [9:0]  beat);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < DATA_WIDTH / 32; k++) begin
      d[32*k +: 32] = {seq, 2'b00, beat, k[3:0]};
    end
    return d;
  endfunction

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d     = state_q;
    beat_d      = beat_q;
    last_beat_d = last_beat_q;
    rem_d       = rem_q;
    seq_d       = seq_q;
    interval_d  = interval_q;
    gap_d       = gap_q;
    num_d       = num_q;
    sent_d      = sent_q;
    beats_d     = beats_q;
    cycles_d    = cycles_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    start_pkt   = 1'b0;
    load        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_SEND;
          num_d     = pkt_num;
          sent_d    = '0;
          beats_d   = '0;
          cycles_d  = '0;
          seq_d     = '0;
          start_pkt = 1'b1;
        end
      end
      S_SEND: begin
        cycles_d = cycles_q + 32'd1;
        if (hs) begin
          beats_d = beats_q + 32'd1;
          if (tlast_q) begin
            sent_d = sent_q + 32'd1;
            seq_d  = seq_q + 16'd1;
            if ((num_q != 32'd0) && (sent_d == num_q)) begin
              state_d = S_DONE;
            end else if (!enable) begin
              state_d = S_IDLE;
            end else if (interval_q == 32'd0) begin
              start_pkt = 1'b1;
            end else begin
              state_d = S_GAP;
              gap_d   = interval_q;
            end
            if (!start_pkt) begin
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end
          end else begin
            beat_d = beat_q + 10'd1;
            load   = 1'b1;
          end
        end
      end
      S_GAP: begin
        cycles_d = cycles_q + 32'd1;
        if (gap_q <= 32'd1) begin
          gap_d = '0;
          if (!enable) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_SEND;
            start_pkt = 1'b1;
          end
        end else begin
          gap_d = gap_q - 32'd1;
        end
      end
      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Config is sampled only here, so a packet in flight never sees a change.
    if (start_pkt) begin
      interval_d  = pkt_interval;
      last_beat_d = new_last_beat;
      rem_d       = new_rem;
      beat_d      = '0;
      load        = 1'b1;
    end

    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_data(seq_d, beat_d);
      tlast_d  = (beat_d == last_beat_d);
      tkeep_d  = tlast_d ? ({KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - int'(rem_d)))
                         : {KEEP_WIDTH{1'b1}};
    end

    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      last_beat_q <= '0;
      rem_q       <= '0;
      seq_q       <= '0;
      interval_q  <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      sent_q      <= '0;
      beats_q     <= '0;
      cycles_q    <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_beat_q <= last_beat_d;
      rem_q       <= rem_d;
      seq_q       <= seq_d;
      interval_q  <= interval_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      sent_q      <= sent_d;
      beats_q     <= beats_d;
      cycles_q    <= cycles_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign m_axis.tvalid    = tvalid_q;
  assign m_axis.tdata     = tdata_q;
  assign m_axis.tkeep     = tkeep_q;
  assign m_axis.tlast     = tlast_q;
  assign m_axis.tuser     = '0;
  assign busy             = busy_q;
  assign done             = done_q;
  assign sent_pkt_count   = sent_q;
  assign total_beat_count = beats_q;
  assign run_cycle_count  = cycles_q;

endmodule

// File: tb/tb_axis_udp_pkt_generator.sv
// Directed bench for axis_udp_pkt_generator: expected beats are queued when a
// run is configured and compared as the DUT hands them off.
module tb_axis_udp_pkt_generator;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    int            exp_gap;   // idle cycles before this beat; -1 = unchecked
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] pkt_size = '0;
  logic [31:0] pkt_interval = '0;
  logic [31:0] pkt_num = '0;
  logic        busy;
  logic        done;
  logic [31:0] sent_pkt_count;
  logic [31:0] total_beat_count;
  logic [31:0] run_cycle_count;

  axis_udp_pkt_generator_if #(.DATA_WIDTH(DW)) axis ();

  axis_udp_pkt_generator #(.DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .pkt_size         (pkt_size),
    .pkt_interval     (pkt_interval),
    .pkt_num          (pkt_num),
    .m_axis           (axis),
    .busy             (busy),
    .done             (done),
    .sent_pkt_count   (sent_pkt_count),
    .total_beat_count (total_beat_count),
    .run_cycle_count  (run_cycle_count)
  );

  initial forever #5 clk = ~clk;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int seq, input int size, input int gap);
    int s;
    int nb;
    s  = (size == 0) ? 1 : size;
    nb = (s + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      beat_t t;
      int    nbytes;
      t.data = '0;
      for (int k = 0; k < 16; k++) t.data[32*k +: 32] = {seq[15:0], b[11:0], k[3:0]};
      t.last  = (b == nb - 1);
      nbytes  = t.last ? s - 64 * b : 64;
      t.keep  = '0;
      for (int i = 0; i < nbytes; i++) t.keep[i] = 1'b1;
      t.exp_gap = (b == 0) ? gap : -1;
      exp_q.push_back(t);
    end
  endtask

  // tready: held high, or a fresh coin flip every cycle while rand_ready is set.
  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, inter-packet gap.
  bit            armed = 1'b0;
  int            idle_run = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] d_prev;
  logic [KW-1:0] k_prev;
  logic          l_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      armed      = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_tvalid", axis.tvalid, 1'b1);
        check("stall_tdata", axis.tdata, d_prev);
        check("stall_tkeep", axis.tkeep, k_prev);
        check("stall_tlast", axis.tlast, l_prev);
      end
      if (armed) begin
        if (!axis.tvalid) begin
          idle_run++;
        end else begin
          armed = 1'b0;
          if (exp_q.size() > 0 && exp_q[0].exp_gap >= 0)
            check("gap_len", idle_run, exp_q[0].exp_gap);
        end
      end
      if (axis.tvalid && axis.tready) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("tdata", axis.tdata, e.data);
          check("tkeep", axis.tkeep, e.keep);
          check("tlast", axis.tlast, e.last);
        end
        if (axis.tlast) begin
          armed    = 1'b1;
          idle_run = 0;
        end
      end
      stall_prev = axis.tvalid && !axis.tready;
      d_prev     = axis.tdata;
      k_prev     = axis.tkeep;
      l_prev     = axis.tlast;
    end
  end

  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("wait_done", done, 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  task automatic wait_sent(input int n, input int budget);
    int i = 0;
    while (sent_pkt_count != n && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("wait_sent", sent_pkt_count, n);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int i = 0;
    while (total_beat_count != n && i < budget) begin
      @(posedge clk); #1; i++;
    end
    check("wait_beats", total_beat_count, n);
  endtask

  task automatic end_run();
    enable = 1'b0;
    @(posedge clk); #1;
    check("done_clear", done, 1'b0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", axis.tvalid, 1'b0);
    check("rst_tlast", axis.tlast, 1'b0);
    check("rst_tkeep", axis.tkeep, '0);
    check("rst_tdata", axis.tdata, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_pkt_count, 0);
    check("rst_beats", total_beat_count, 0);
    check("rst_cycles", run_cycle_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four single-beat packets back to back at full rate.
    pkt_size = 16'd64; pkt_interval = 0; pkt_num = 4;
    for (int s = 0; s < 4; s++) push_pkt(s, 64, (s == 0) ? -1 : 0);
    enable = 1'b1;
    @(posedge clk); #1;
    check("start_latency", axis.tvalid, 1'b1);
    wait_done(100);
    check("t1_sent", sent_pkt_count, 4);
    check("t1_beats", total_beat_count, 4);
    check("t1_cycles", run_cycle_count, 4);
    check("t1_busy", busy, 1'b0);
    end_run();

    // 130 bytes: three beats, last beat holds 2 bytes.
    pkt_size = 16'd130; pkt_interval = 0; pkt_num = 1;
    push_pkt(0, 130, -1);
    enable = 1'b1;
    wait_done(100);
    check("t2_sent", sent_pkt_count, 1);
    check("t2_beats", total_beat_count, 3);
    end_run();

    // Four-beat packets with a 10-cycle gap.
    pkt_size = 16'd256; pkt_interval = 10; pkt_num = 3;
    for (int s = 0; s < 3; s++) push_pkt(s, 256, (s == 0) ? -1 : 10);
    enable = 1'b1;
    wait_done(200);
    check("t3_sent", sent_pkt_count, 3);
    check("t3_beats", total_beat_count, 12);
    check("t3_cycles", run_cycle_count, 32);
    end_run();

    // Random backpressure, 16-beat packets with a 40-byte tail.
    rand_ready = 1'b1;
    pkt_size = 16'd1000; pkt_interval = 3; pkt_num = 20;
    for (int s = 0; s < 20; s++) push_pkt(s, 1000, (s == 0) ? -1 : 3);
    enable = 1'b1;
    wait_done(5000);
    check("t4_sent", sent_pkt_count, 20);
    check("t4_beats", total_beat_count, 320);
    rand_ready = 1'b0;
    end_run();

    // Unlimited run; enable dropped during packet 5 stops at its boundary.
    pkt_size = 16'd128; pkt_interval = 0; pkt_num = 0;
    for (int s = 0; s < 5; s++) push_pkt(s, 128, (s == 0) ? -1 : 0);
    enable = 1'b1;
    wait_sent(4, 100);
    enable = 1'b0;
    wait_idle(100);
    check("t5_sent", sent_pkt_count, 5);
    check("t5_beats", total_beat_count, 10);
    check("t5_tvalid", axis.tvalid, 1'b0);
    check("t5_done", done, 1'b0);
    check("t5_queue", exp_q.size(), 0);

    // Reset during beat 2 of a 4-beat packet, then a fresh run from seq 0.
    pkt_size = 16'd256; pkt_interval = 0; pkt_num = 0;
    push_pkt(0, 256, -1);
    enable = 1'b1;
    wait_beats(2, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid", axis.tvalid, 1'b0);
    check("rst_mid_tlast", axis.tlast, 1'b0);
    check("rst_mid_sent", sent_pkt_count, 0);
    check("rst_mid_beats", total_beat_count, 0);
    check("rst_mid_cycles", run_cycle_count, 0);
    check("rst_mid_busy", busy, 1'b0);
    exp_q.delete();
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_size = 16'd64; pkt_interval = 0; pkt_num = 1;
    push_pkt(0, 64, -1);
    enable = 1'b1;
    wait_done(100);
    check("t6_sent", sent_pkt_count, 1);
    check("t6_beats", total_beat_count, 1);
    end_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
